// File: rtl/jtpopeye_sdram_pkg.sv
// jtpopeye_sdram_pkg: SDRAM command encodings {cs_n,ras_n,cas_n,we_n}, controller states and mode word
package jtpopeye_sdram_pkg;
    typedef enum logic [3:0] {
        INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE, ACT, RD, WR, RDWAIT, REF
    } state_t;
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_ACT = 4'b0011;
    localparam logic [3:0] CMD_RD  = 4'b0101;
    localparam logic [3:0] CMD_WR  = 4'b0100;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;
    // burst 2, sequential, CAS latency 2
    localparam logic [12:0] MODE_REG = 13'h021;
endpackage

// File: rtl/jtpopeye_sdram_refcnt.sv
// jtpopeye_sdram_refcnt: free-running refresh timer raising a sticky pending flag each period
module jtpopeye_sdram_refcnt #(
    parameter int REF_PERIOD = 156
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic pending
);
    logic [15:0] cnt;
    logic        wrap;
    assign wrap = cnt == 16'(REF_PERIOD - 1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else begin
            cnt     <= wrap ? '0 : cnt + 16'd1;
            pending <= wrap | (pending & ~clr);
        end
    end
endmodule

// File: rtl/jtpopeye_sdram.sv
// jtpopeye_sdram: single-bank SDRAM controller for ROM download writes and 32-bit burst reads.
// JTPOPEYE_SDRAM_FASTINIT_EN shortens the power-up wait to 16 cycles for simulation.
module jtpopeye_sdram
    import jtpopeye_sdram_pkg::*;
#(
    parameter int INIT_WAIT  = 2000,
    parameter int REF_PERIOD = 156,
    parameter int TRCD       = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        prog_we,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    output logic        sdram_ack,
    output logic        data_rdy,
    output logic [31:0] data_read,
    input  logic        refresh_en,
    output logic        loop_rst,
    output logic [12:0] sd_a,
    output logic [1:0]  sd_ba,
    output logic        sd_cs_n,
    output logic        sd_ras_n,
    output logic        sd_cas_n,
    output logic        sd_we_n,
    output logic [1:0]  sd_dqm,
    output logic        sd_cke,
    input  logic [15:0] sd_dq_i,
    output logic [15:0] sd_dq_o,
    output logic        sd_dq_oe
);
`ifdef JTPOPEYE_SDRAM_FASTINIT_EN
    localparam int WAIT_CYC = 16;
`else
    localparam int WAIT_CYC = INIT_WAIT;
`endif
    state_t      state;
    logic [15:0] cnt;
    logic [3:0]  cmd;
    logic [21:0] addr, wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  wr_mask;
    logic        ref_n, is_wr, wr_pend, ref_pend, ref_go, ref_clr;

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd;
    assign sd_cke  = 1'b1;
    assign sd_ba   = 2'b00;
    assign ref_go  = ref_pend & (refresh_en | downloading);
    assign ref_clr = state == IDLE && ref_go;

    jtpopeye_sdram_refcnt #(.REF_PERIOD(REF_PERIOD)) u_refcnt (
        .clk(clk), .rst_n(rst_n), .clr(ref_clr), .pending(ref_pend)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= jtpopeye_sdram_pkg::INIT_WAIT;
            cnt       <= '0;
            cmd       <= CMD_NOP;
            sd_a      <= '0;
            sd_dqm    <= 2'b11;
            sd_dq_o   <= '0;
            sd_dq_oe  <= 1'b0;
            loop_rst  <= 1'b1;
            sdram_ack <= 1'b0;
            data_rdy  <= 1'b0;
            data_read <= '0;
            addr      <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_mask   <= '0;
            wr_pend   <= 1'b0;
            ref_n     <= 1'b0;
            is_wr     <= 1'b0;
        end else begin
            cmd       <= CMD_NOP;
            sdram_ack <= 1'b0;
            data_rdy  <= 1'b0;
            sd_dq_oe  <= 1'b0;
            cnt       <= cnt + 16'd1;
            if (prog_we && !wr_pend) begin
                wr_pend <= 1'b1;
                wr_addr <= prog_addr;
                wr_data <= prog_data;
                wr_mask <= prog_mask;
            end
            case (state)
                jtpopeye_sdram_pkg::INIT_WAIT: if (cnt == 16'(WAIT_CYC - 1)) begin
                    cmd   <= CMD_PRE;
                    sd_a  <= 13'h400;
                    cnt   <= '0;
                    state <= INIT_PRE;
                end
                INIT_PRE: if (cnt == 16'd1) begin
                    cmd   <= CMD_REF;
                    cnt   <= '0;
                    ref_n <= 1'b0;
                    state <= INIT_REF;
                end
                INIT_REF: if (cnt == 16'd8) begin
                    cmd   <= ref_n ? CMD_MRS : CMD_REF;
                    sd_a  <= MODE_REG;
                    cnt   <= '0;
                    ref_n <= 1'b1;
                    if (ref_n) state <= INIT_MRS;
                end
                INIT_MRS: if (cnt == 16'd1) begin
                    state    <= IDLE;
                    loop_rst <= 1'b0;
                    sd_dqm   <= 2'b00;
                end
                IDLE: begin
                    cnt <= '0;
                    if (ref_go) begin
                        cmd   <= CMD_REF;
                        state <= REF;
                    end else if (wr_pend || (sdram_req && !downloading)) begin
                        cmd       <= CMD_ACT;
                        is_wr     <= wr_pend;
                        sdram_ack <= !wr_pend;
                        addr      <= wr_pend ? wr_addr : sdram_addr;
                        sd_a      <= wr_pend ? wr_addr[21:9] : sdram_addr[21:9];
                        state     <= ACT;
                    end
                end
                ACT: if (cnt == 16'(TRCD - 1)) begin
                    cmd   <= is_wr ? CMD_WR : CMD_RD;
                    sd_a  <= {3'b001, 1'b0, addr[8:0]};
                    state <= is_wr ? WR : RD;
                    if (is_wr) begin
                        wr_pend  <= 1'b0;
                        sd_dq_oe <= 1'b1;
                        sd_dq_o  <= {wr_data, wr_data};
                        sd_dqm   <= wr_mask;
                    end
                end
                RD: state <= RDWAIT;
                WR: begin
                    sd_dqm <= 2'b00;
                    if (cnt == 16'(TRCD + 3)) state <= IDLE;
                end
                // CAS latency 2: words land two and three cycles after READ is sampled
                RDWAIT: begin
                    if (cnt == 16'(TRCD + 2)) data_read[15:0] <= sd_dq_i;
                    if (cnt == 16'(TRCD + 3)) begin
                        data_read[31:16] <= sd_dq_i;
                        data_rdy         <= 1'b1;
                        state            <= IDLE;
                    end
                end
                REF: if (cnt == 16'd3) state <= IDLE;
                default: state <= jtpopeye_sdram_pkg::INIT_WAIT;
            endcase
        end
    end
endmodule
